// File: rtl/audit_log_reader.sv
// rtl/audit_log_reader.sv - audit archive read-back: query, burst fetch, record reassembly and checks
//
// Accepts a (start, count) query, clamps it against the committed tail, fetches
// each 1216-bit record as 19 x 64-bit beats starting at word address idx*19,
// checks timestamp ordering and presents records on a valid/ready stream.
// Record layout {hash[511:0], timestamp[63:0], did[127:0], event[255:0], resource[255:0]};
// beat 0 carries the most significant 64 bits.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   q_valid/q_ready, q_start, q_count query handshake and parameters
//   log_tail                          committed record count, sampled at query accept
//   ar_valid/ar_ready, ar_addr        archive burst read request
//   r_valid, r_data                   archive read beats (no backpressure)
//   rec_valid/rec_ready, rec_*        reassembled record stream
//   busy, done                        query in progress / one-cycle end pulse
//   err_range, err_order, err_timeout sticky errors, cleared at next query accept
//
// Optional feature macro: AUDIT_DID_FILTER_EN
//   adds q_did_en/q_did; records whose DID differs from q_did are skipped.
module audit_log_reader #(
    parameter int IDX_W     = 32,
    parameter int ADDR_W    = 40,
    parameter int STALL_MAX = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              q_valid,
    output logic              q_ready,
    input  logic [IDX_W-1:0]  q_start,
    input  logic [IDX_W-1:0]  q_count,
    input  logic [IDX_W-1:0]  log_tail,
`ifdef AUDIT_DID_FILTER_EN
    input  logic              q_did_en,
    input  logic [127:0]      q_did,
`endif
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    input  logic              r_valid,
    input  logic [63:0]       r_data,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [IDX_W-1:0]  rec_idx,
    output logic [511:0]      rec_hash,
    output logic [63:0]       rec_timestamp,
    output logic [127:0]      rec_did,
    output logic [255:0]      rec_event,
    output logic [255:0]      rec_resource,
    output logic              busy,
    output logic              done,
    output logic              err_range,
    output logic              err_order,
    output logic              err_timeout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_BEAT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    localparam int                 STALL_W   = $clog2(STALL_MAX + 1);
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);
    localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);

    logic [2:0]         state_q,   state_d;
    logic               q_ready_q, q_ready_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [IDX_W-1:0]   rem_q,     rem_d;
    logic [4:0]         beat_q,    beat_d;
    logic [STALL_W-1:0] stall_q,   stall_d;
    logic [1215:0]      asm_q,     asm_d;
    logic [1215:0]      rec_q,     rec_d;
    logic [IDX_W-1:0]   rec_idx_q, rec_idx_d;
    logic [63:0]        prev_ts_q, prev_ts_d;
    logic               first_q,   first_d;
    logic               err_range_q,   err_range_d;
    logic               err_order_q,   err_order_d;
    logic               err_timeout_q, err_timeout_d;

    logic [IDX_W:0]     q_end;
    logic [IDX_W-1:0]   q_clamp;
    logic [63:0]        asm_ts;
    logic               skip;

    // Range check is done one bit wider so start+count cannot wrap past the tail.
    assign q_end   = {1'b0, q_start} + {1'b0, q_count};
    assign q_clamp = (q_start >= log_tail) ? '0 : log_tail - q_start;
    assign asm_ts  = asm_q[703:640];

`ifdef AUDIT_DID_FILTER_EN
    logic         did_en_q, did_en_d;
    logic [127:0] did_q,    did_d;
    assign skip = did_en_q && (asm_q[639:512] != did_q);
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        rem_d         = rem_q;
        beat_d        = beat_q;
        stall_d       = stall_q;
        asm_d         = asm_q;
        rec_d         = rec_q;
        rec_idx_d     = rec_idx_q;
        prev_ts_d     = prev_ts_q;
        first_d       = first_q;
        err_range_d   = err_range_q;
        err_order_d   = err_order_q;
        err_timeout_d = err_timeout_q;
`ifdef AUDIT_DID_FILTER_EN
        did_en_d      = did_en_q;
        did_d         = did_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (q_valid && q_ready_q) begin
                    err_range_d   = 1'b0;
                    err_order_d   = 1'b0;
                    err_timeout_d = 1'b0;
                    first_d       = 1'b1;
                    idx_d         = q_start;
                    rem_d         = q_count;
                    if (q_end > {1'b0, log_tail}) begin
                        err_range_d = 1'b1;
                        rem_d       = q_clamp;
                    end
`ifdef AUDIT_DID_FILTER_EN
                    did_en_d = q_did_en;
                    did_d    = q_did;
`endif
                    state_d = (rem_d == '0) ? S_FIN : S_REQ;
                end
            end
            S_REQ: begin
                if (ar_ready) begin
                    beat_d  = '0;
                    stall_d = '0;
                    state_d = S_BEAT;
                end
            end
            S_BEAT: begin
                if (r_valid) begin
                    asm_d   = {asm_q[1151:0], r_data};
                    beat_d  = beat_q + 5'd1;
                    stall_d = '0;
                    if (beat_q == 5'd18) begin
                        state_d = S_CHECK;
                    end
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                    // Abandon the partial record; nothing of it is ever presented.
                    if (stall_d == STALL_LIM) begin
                        err_timeout_d = 1'b1;
                        state_d       = S_FIN;
                    end
                end
            end
            S_CHECK: begin
                if (!first_q && (asm_ts < prev_ts_q)) begin
                    err_order_d = 1'b1;
                end
                prev_ts_d = asm_ts;
                first_d   = 1'b0;
                if (skip) begin
                    idx_d   = idx_q + IDX_ONE;
                    rem_d   = rem_q - IDX_ONE;
                    state_d = (rem_q == IDX_ONE) ? S_FIN : S_REQ;
                end else begin
                    rec_d     = asm_q;
                    rec_idx_d = idx_q;
                    state_d   = S_OUT;
                end
            end
            S_OUT: begin
                if (rec_ready) begin
                    idx_d   = idx_q + IDX_ONE;
                    rem_d   = rem_q - IDX_ONE;
                    state_d = (rem_q == IDX_ONE) ? S_FIN : S_REQ;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Registered so q_ready stays low while reset is asserted.
        q_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            q_ready_q     <= 1'b0;
            idx_q         <= '0;
            rem_q         <= '0;
            beat_q        <= '0;
            stall_q       <= '0;
            asm_q         <= '0;
            rec_q         <= '0;
            rec_idx_q     <= '0;
            prev_ts_q     <= '0;
            first_q       <= 1'b0;
            err_range_q   <= 1'b0;
            err_order_q   <= 1'b0;
            err_timeout_q <= 1'b0;
`ifdef AUDIT_DID_FILTER_EN
            did_en_q      <= 1'b0;
            did_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            q_ready_q     <= q_ready_d;
            idx_q         <= idx_d;
            rem_q         <= rem_d;
            beat_q        <= beat_d;
            stall_q       <= stall_d;
            asm_q         <= asm_d;
            rec_q         <= rec_d;
            rec_idx_q     <= rec_idx_d;
            prev_ts_q     <= prev_ts_d;
            first_q       <= first_d;
            err_range_q   <= err_range_d;
            err_order_q   <= err_order_d;
            err_timeout_q <= err_timeout_d;
`ifdef AUDIT_DID_FILTER_EN
            did_en_q      <= did_en_d;
            did_q         <= did_d;
`endif
        end
    end

    assign q_ready       = q_ready_q;
    assign ar_valid      = (state_q == S_REQ);
    assign ar_addr       = ar_valid ? ADDR_W'(idx_q) * ADDR_W'(19) : '0;
    assign rec_valid     = (state_q == S_OUT);
    assign rec_idx       = rec_idx_q;
    assign rec_hash      = rec_q[1215:704];
    assign rec_timestamp = rec_q[703:640];
    assign rec_did       = rec_q[639:512];
    assign rec_event     = rec_q[511:256];
    assign rec_resource  = rec_q[255:0];
    assign busy          = (state_q == S_REQ) || (state_q == S_BEAT) ||
                           (state_q == S_CHECK) || (state_q == S_OUT);
    assign done          = (state_q == S_FIN);
    assign err_range     = err_range_q;
    assign err_order     = err_order_q;
    assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_audit_log_reader.sv
// tb/tb_audit_log_reader.sv - scoreboard testbench for audit_log_reader
module tb_audit_log_reader;

    localparam int STALL_MAX = 1023;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          q_valid = 1'b0;
    logic          q_ready;
    logic [31:0]   q_start = '0;
    logic [31:0]   q_count = '0;
    logic [31:0]   log_tail = '0;
    logic          ar_valid;
    logic          ar_ready = 1'b0;
    logic [39:0]   ar_addr;
    logic          r_valid = 1'b0;
    logic [63:0]   r_data = '0;
    logic          rec_valid;
    logic          rec_ready = 1'b0;
    logic [31:0]   rec_idx;
    logic [511:0]  rec_hash;
    logic [63:0]   rec_timestamp;
    logic [127:0]  rec_did;
    logic [255:0]  rec_event;
    logic [255:0]  rec_resource;
    logic          busy;
    logic          done;
    logic          err_range;
    logic          err_order;
    logic          err_timeout;

    audit_log_reader #(.IDX_W(32), .ADDR_W(40), .STALL_MAX(STALL_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .q_valid(q_valid), .q_ready(q_ready), .q_start(q_start), .q_count(q_count),
        .log_tail(log_tail),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_data(r_data),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_idx(rec_idx),
        .rec_hash(rec_hash), .rec_timestamp(rec_timestamp), .rec_did(rec_did),
        .rec_event(rec_event), .rec_resource(rec_resource),
        .busy(busy), .done(done),
        .err_range(err_range), .err_order(err_order), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [1215:0] rec;
        bit            ord;
    } exp_t;

    exp_t          exp_q[$];
    longint        addr_q[$];
    logic [1215:0] arch [0:63];

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int pop_cnt = 0;
    int gap_pct = 0;
    int ar_pct = 100;
    int rdy_pct = 100;
    int stop_at = -1;
    int hold_n = 0;
    bit junk_en = 0;
    bit streaming = 0;
    int beat_i = 0;

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [1215:0] mk_rec(input logic [63:0] ts);
        logic [1215:0] r;
        for (int k = 0; k < 38; k++) r[k*32 +: 32] = $urandom;
        r[703:640] = ts;
        return r;
    endfunction

    // Archive side: accepts read requests and streams the addressed record as 19 beats.
    initial begin : responder
        logic [1215:0] cur;
        bit            hs_pend;
        longint        hs_addr;
        cur = '0;
        hs_pend = 0;
        hs_addr = 0;
        forever begin
            @(posedge clk);
            if (r_valid && streaming) beat_i++;
            if (beat_i >= 19) streaming = 0;
            if (hs_pend) begin
                streaming = 1;
                beat_i = 0;
                cur = arch[int'(hs_addr / 19) % 64];
            end
            #1;
            r_valid = 0;
            r_data = '0;
            ar_ready = 0;
            hs_pend = 0;
            if (!rst_n) begin
                streaming = 0;
                rec_ready = 0;
            end else begin
                if (ar_valid) begin
                    chk("ar_pending", addr_q.size() > 0, 1);
                    if (addr_q.size() > 0) chk("ar_addr", ar_addr, addr_q[0]);
                    if ($urandom_range(99) < ar_pct) begin
                        ar_ready = 1;
                        hs_pend = 1;
                        hs_addr = longint'(ar_addr);
                        if (addr_q.size() > 0) void'(addr_q.pop_front());
                    end
                end
                if (streaming && !(stop_at >= 0 && beat_i >= stop_at) && ($urandom_range(99) >= gap_pct)) begin
                    r_valid = 1;
                    r_data = cur[1215 - 64*beat_i -: 64];
                end else if (!streaming && junk_en && ($urandom_range(99) < 10)) begin
                    r_valid = 1;
                    r_data = {$urandom, $urandom};
                end
                if (rec_valid && hold_n > 0) begin
                    rec_ready = 0;
                    hold_n--;
                end else begin
                    rec_ready = ($urandom_range(99) < rdy_pct);
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on every record handshake.
    initial begin : monitor
        exp_t          e;
        bit            held;
        logic [1247:0] snap;
        logic [1247:0] now;
        held = 0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 0;
            end else begin
                if (done) done_cnt++;
                if (rec_valid) begin
                    now = {rec_idx, rec_hash, rec_timestamp, rec_did, rec_event, rec_resource};
                    chk("no_ar_during_out", ar_valid, 0);
                    if (held) chk("rec_stable", now === snap, 1);
                    if (rec_ready) begin
                        held = 0;
                        pop_cnt++;
                        chk("rec_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            chk("rec_idx", rec_idx, e.idx);
                            chk("rec_hash", rec_hash, e.rec[1215:704]);
                            chk("rec_timestamp", rec_timestamp, e.rec[703:640]);
                            chk("rec_did", rec_did, e.rec[639:512]);
                            chk("rec_event", rec_event, e.rec[511:256]);
                            chk("rec_resource", rec_resource, e.rec[255:0]);
                            chk("err_order_at_rec", err_order, e.ord);
                        end
                    end else begin
                        held = 1;
                        snap = now;
                    end
                end
            end
        end
    end

    // Reference model: clamp the query against the tail and list the records it must yield.
    task automatic plan_query(input int start, input int count, input int tail, input bit to_mode,
                              output int n, output bit rng, output bit ord);
        logic [63:0] prev;
        logic [63:0] ts;
        exp_t        e;
        rng = (start + count) > tail;
        n = !rng ? count : ((start >= tail) ? 0 : tail - start);
        ord = 0;
        prev = '0;
        if (to_mode) begin
            addr_q.push_back(longint'(start) * 19);
        end else begin
            for (int i = 0; i < n; i++) begin
                ts = arch[start + i][703:640];
                if (i > 0 && ts < prev) ord = 1;
                prev = ts;
                e.idx = start + i;
                e.rec = arch[start + i];
                e.ord = ord;
                exp_q.push_back(e);
                addr_q.push_back(longint'(start + i) * 19);
            end
        end
    endtask

    task automatic issue_query(input int start, input int count, input int tail);
        for (int c = 0; c < 50 && !q_ready; c++) begin
            @(posedge clk); #1;
        end
        chk("q_ready_idle", q_ready, 1);
        q_valid = 1;
        q_start = start;
        q_count = count;
        log_tail = tail;
        @(posedge clk); #1;
        q_valid = 0;
        q_start = $urandom;
        q_count = $urandom;
        log_tail = $urandom;
    endtask

    task automatic run_query(input int start, input int count, input int tail, input bit to_mode,
                             output int cyc);
        int n;
        bit rng;
        bit ord;
        int d0;
        int limit;
        plan_query(start, count, tail, to_mode, n, rng, ord);
        d0 = done_cnt;
        issue_query(start, count, tail);
        chk("busy_after_accept", busy, n > 0);
        limit = to_mode ? STALL_MAX + 200 : 200 + n * 400;
        cyc = 0;
        while (done_cnt == d0 && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", done_cnt != d0, 1);
        chk("err_range", err_range, rng);
        chk("err_order", err_order, to_mode ? 1'b0 : ord);
        chk("err_timeout", err_timeout, to_mode);
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt - d0, 1);
        chk("records_left", exp_q.size(), 0);
        chk("reads_left", addr_q.size(), 0);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_q_ready"}, q_ready, 0);
        chk({tag, "_ar_valid"}, ar_valid, 0);
        chk({tag, "_ar_addr"}, ar_addr, 0);
        chk({tag, "_rec_valid"}, rec_valid, 0);
        chk({tag, "_rec_idx"}, rec_idx, 0);
        chk({tag, "_rec_hash"}, rec_hash, 0);
        chk({tag, "_rec_fields"}, {rec_timestamp, rec_did, rec_event}, 0);
        chk({tag, "_rec_resource"}, rec_resource, 0);
        chk({tag, "_status"}, {busy, done, err_range, err_order, err_timeout}, 0);
    endtask

    initial begin : main
        int cyc;
        int n;
        bit rng;
        bit ord;
        int p0;
        int c;
        int start;
        int count;
        int tail;
        for (int i = 0; i < 64; i++) arch[i] = mk_rec(64'(1000 + i * 10));

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1;
        @(posedge clk); #1;

        // Basic two-record fetch.
        run_query(0, 2, 5, 0, cyc);
        // Query running past the tail is clamped to records 3 and 4.
        run_query(3, 4, 5, 0, cyc);
        // Timestamps 100, 100, 90: only the third record flags an ordering error.
        arch[10] = mk_rec(64'd100);
        arch[11] = mk_rec(64'd100);
        arch[12] = mk_rec(64'd90);
        run_query(10, 3, 20, 0, cyc);
        // Downstream holds off the first record for 10 cycles.
        hold_n = 10;
        run_query(0, 2, 5, 0, cyc);
        // Archive stops after seven beats.
        stop_at = 7;
        run_query(0, 1, 5, 1, cyc);
        chk("timeout_latency_lo", cyc >= STALL_MAX + 4, 1);
        chk("timeout_latency_hi", cyc <= STALL_MAX + 16, 1);
        stop_at = -1;

        // Asynchronous reset during the tenth beat of the second record of a clamped query.
        plan_query(3, 4, 5, 0, n, rng, ord);
        p0 = pop_cnt;
        issue_query(3, 4, 5);
        c = 0;
        while (!(pop_cnt > p0 && streaming && beat_i >= 10) && c < 2000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("abort_point_reached", c < 2000, 1);
        chk("err_range_before_abort", err_range, 1);
        #2;
        rst_n = 0;
        #1;
        chk_all_zero("async_reset");
        exp_q.delete();
        addr_q.delete();
        hold_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_held");
        rst_n = 1;
        @(posedge clk); #1;
        run_query(0, 2, 5, 0, cyc);

        // Randomised queries with gaps, request delays, backpressure and stray beats.
        gap_pct = 20;
        ar_pct = 60;
        rdy_pct = 70;
        junk_en = 1;
        repeat (25) begin
            tail = $urandom_range(40);
            start = $urandom_range(45);
            count = $urandom_range(8);
            for (int k = start; k < start + count && k < 64; k++) begin
                arch[k] = mk_rec(64'($urandom_range(50)));
            end
            if ($urandom_range(3) == 0) hold_n = $urandom_range(6);
            run_query(start, count, tail, 0, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog simulation did not finish got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/audit_log_reader.md
Name: audit_log_reader

Overview:
- Read-back side of the audit logging path.
- Accepts a query (start index, record count) and fetches committed records from the append-only audit archive over a burst read interface.
- Reassembles each 1216-bit record from 64-bit beats, checks timestamp ordering and archive bounds, and presents each record on a valid/ready output stream to compliance/export logic.

Parameters:
- IDX_W, 32, width of record index, count and tail values.
- ADDR_W, 40, archive word (64-bit) address width.
- STALL_MAX, 1023, maximum cycles waiting on an archive beat before err_timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- q_valid  in  1  query valid.
- q_ready  out  1  query accepted when q_valid&&q_ready.
- q_start  in  IDX_W  first record index.
- q_count  in  IDX_W  number of records requested.
- log_tail  in  IDX_W  number of committed records in archive (sampled at query accept).
- ar_valid  out  1  archive read request.
- ar_ready  in  1  archive accepts request.
- ar_addr  out  ADDR_W  word address = idx*19.
- r_valid  in  1  read beat valid (no backpressure).
- r_data  in  64  read beat data.
- rec_valid  out  1  record output valid.
- rec_ready  in  1  downstream accepts record.
- rec_idx  out  IDX_W  index of presented record.
- rec_hash  out  512  stored hash.
- rec_timestamp  out  64  stored timestamp.
- rec_did  out  128  user DID.
- rec_event  out  256  event data.
- rec_resource  out  256  resource id.
- busy  out  1  query in progress.
- done  out  1  one-cycle pulse at query end.
- err_range  out  1  sticky: query exceeded log_tail.
- err_order  out  1  sticky: timestamp decreased.
- err_timeout  out  1  sticky: beat stall exceeded STALL_MAX.

Behaviour:
- Reset values: all outputs 0, including all rec_* fields and sticky errors. FSM returns to IDLE and internal counters clear.
- Record layout: {hash, timestamp, did, event, resource}, 1216 bits, 19 beats; beat 0 carries bits [1215:1152], beat 18 carries [63:0].
- FSM states and transitions:
  - IDLE: q_ready=1. On accept, latch start, count and log_tail.
    - If start+count > tail (compare at IDX_W+1 bits): set err_range and clamp count to tail-start, or 0 if start>=tail.
    - Clear sticky errors on accept, before applying the range check.
    - Count==0 after clamp: go to FIN.
    - Otherwise go to REQ with idx=start; busy=1 from the cycle after accept.
  - REQ: ar_valid=1, ar_addr=idx*19, both held stable until ar_ready. Then go to BEAT with beat counter=0.
  - BEAT: each r_valid shifts r_data into the assembly register and increments the beat counter.
    - Stall counter resets on every beat.
    - Stall reaching STALL_MAX: set err_timeout and go to FIN; a partial record is never emitted.
    - On beat 18: go to CHECK.
  - CHECK (1 cycle):
    - If not the first record of the query and timestamp < previous timestamp: set err_order. The record is still emitted.
    - Update previous timestamp, load the rec_* registers, go to OUT.
  - OUT: rec_valid=1, rec_* held stable until rec_ready.
    - On handshake: idx++, remaining--. Remaining==0 goes to FIN; otherwise go to REQ.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- r_valid outside BEAT is ignored.
- Latency: ar handshake to rec_valid is 20 cycles minimum (19 beats + CHECK).
- Equal timestamps are legal.
- Index arithmetic is modulo 2^IDX_W; a clamp guarantees no wrap inside a query.
- Async reset mid-query: abort immediately, drop any in-flight beats, no done pulse.

Optional Feature:
- Macro AUDIT_DID_FILTER_EN.
  - Defined: adds inputs q_did_en (1) and q_did (128), latched at query accept. In CHECK, a record whose rec_did != q_did while q_did_en=1 is skipped: no rec_valid, idx++/remaining-- directly, go to REQ or FIN. Ordering checks still apply to skipped records.
  - Undefined: ports absent and every fetched record is emitted.

Test Plan:
- Reset, then query start=0, count=2, tail=5, ar_ready=1, beats back-to-back:
  - ar_addr=0 then 19.
  - Two records emitted, rec_idx 0 and 1, with fields matching the beat data.
  - done pulses once; no errors.
- Query start=3, count=4, tail=5 -> err_range=1, exactly 2 records emitted (idx 3, 4), then done.
- Timestamps 100, 100, 90 across 3 records -> all 3 emitted; err_order rises on record idx 2 only.
- Hold rec_ready=0 for 10 cycles on record 0 -> rec_* stable, no new ar_valid, resumes correctly on release.
- Stop r_valid after beat 7 -> err_timeout after STALL_MAX cycles, no rec_valid, done pulse, FSM back in IDLE.
- Assert rst_n=0 during beat 10 -> all outputs 0 asynchronously; a new query afterwards fetches clean records with sticky errors clear.
